// File: rtl/multiplier_if.sv
// multiplier_intf: shared bundle between the multiplier control FSM and its
// datapath. The environment drives rst_n, start and datain; control drives
// done and the datapath strobes; the datapath reports eqz.
//   clk    : system clock, rising edge (interface port)
//   rst_n  : synchronous active-low reset
//   start  : level request from the environment
//   datain : operand bus, A in the start cycle, B in the following cycle
//   done   : product valid
//   ldA, ldB, clrP, step : control -> datapath strobes
//   eqz    : datapath -> control, iteration counter at its last step
interface multiplier_intf #(
  parameter int WIDTH = 8
) (
  input logic clk
);
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] datain;
  logic             done;
  logic             ldA;
  logic             ldB;
  logic             clrP;
  logic             step;
  logic             eqz;

  modport mul_control (
    input  clk,
    input  rst_n,
    input  start,
    input  eqz,
    output done,
    output ldA,
    output ldB,
    output clrP,
    output step
  );

  modport mul_datapath (
    input  clk,
    input  rst_n,
    input  datain,
    input  ldA,
    input  ldB,
    input  clrP,
    input  step,
    output eqz
  );
endinterface

// File: rtl/multiplier.sv
// Sequential unsigned shift-and-add multiplier.
//   control  : four-state FSM sequencing operand load, WIDTH add/shift steps
//              and the done handshake.
//   datapath : operand registers, shifted multiplicand, iteration counter and
//              the 2*WIDTH-bit product register y.
//   multiplier (top):
//     clk    : system clock, rising edge
//     rst_n  : synchronous active-low reset
//     start  : level request; must fall before another product is started
//     datain : operand bus, A at the start edge, B at the next edge
//     done   : product valid (held while start stays high)
//     y      : product register (partial sums while calculating)

module control (
  multiplier_intf.mul_control bus
);
  typedef enum logic [1:0] {
    IDLE,
    LOAD_B,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge bus.clk) begin
    if (!bus.rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bus.ldA    = 1'b0;
    bus.ldB    = 1'b0;
    bus.clrP   = 1'b0;
    bus.step   = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ldA = bus.start;
        if (bus.start) begin
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        bus.ldB    = 1'b1;
        bus.clrP   = 1'b1;
        state_next = CALC;
      end
      CALC: begin
        bus.step = 1'b1;
        if (bus.eqz) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // done decodes the state register, so it is glitch-free and stable
        // for as long as start is held.
        bus.done = 1'b1;
        if (!bus.start) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

module datapath #(
  parameter int WIDTH = 8
) (
  multiplier_intf.mul_datapath bus
);
  localparam int PW = 2 * WIDTH;
  // One spare count value so the counter never wraps back onto WIDTH-1.
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [PW-1:0]    sa;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    y;

  assign bus.eqz = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge bus.clk) begin
    if (!bus.rst_n) begin
      a   <= '0;
      b   <= '0;
      sa  <= '0;
      cnt <= '0;
      y   <= '0;
    end else begin
      if (bus.ldA) begin
        a <= bus.datain;
      end
      if (bus.ldB) begin
        b <= bus.datain;
      end
      if (bus.clrP) begin
        y   <= '0;
        cnt <= '0;
        sa  <= PW'(a);
      end else if (bus.step) begin
        if (b[0]) begin
          y <= y + sa;
        end
        sa  <= sa << 1;
        b   <= b >> 1;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   datain,
  output logic               done,
  output logic [2*WIDTH-1:0] y
);
  multiplier_intf #(.WIDTH(WIDTH)) bus (.clk(clk));

  assign bus.rst_n  = rst_n;
  assign bus.start  = start;
  assign bus.datain = datain;
  assign done       = bus.done;

  control u_control (
    .bus(bus.mul_control)
  );

  datapath #(.WIDTH(WIDTH)) u_datapath (
    .bus(bus.mul_datapath)
  );

  // The product register lives in the datapath and is read out by name.
  assign y = u_datapath.y;
endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the shift-and-add multiplier (WIDTH = 8).
module tb_multiplier;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   datain;
  logic           done;
  logic [2*W-1:0] y;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .datain(datain),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product, straight unsigned arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[2*W-1:0];
  endfunction

  // Presents A at E0 and B at E0+1; returns just after E0+1.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start  = 1'b1;
    datain = a;
    tick();
    datain = b;
    tick();
    datain = W'($urandom);
  endtask

  // Counts edges until done is seen (bounded); done must not be seen early.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  vec_t vecs[$];
  int   n;
  logic [2*W-1:0] held;
  logic [W-1:0]   ra, rb;

  initial begin
    vecs.push_back('{8'h24, 8'h81, 16'h1224});
    vecs.push_back('{8'hFF, 8'hFF, 16'hFE01});
    vecs.push_back('{8'h00, 8'hAB, 16'h0000});
    vecs.push_back('{8'h01, 8'h80, 16'h0080});
    vecs.push_back('{8'h0C, 8'h0D, 16'd156});
    vecs.push_back('{8'h07, 8'h06, 16'd42});

    rst_n  = 1'b0;
    start  = 1'b0;
    datain = '0;
    tick();
    tick();
    check("reset_done", 32'(done), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table: done appears WIDTH edges after E0+1 (after E0+W+1).
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(n);
      check("tbl_latency", 32'(n), 32'(W));
      check("tbl_product", 32'(y), 32'(vecs[i].exp));
      start = 1'b0;
      tick();
      check("tbl_rearm_done", 32'(done), 32'd0);
    end

    // Randomized operands against the arithmetic model.
    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      start_op(ra, rb);
      wait_done(n);
      check("rnd_latency", 32'(n), 32'(W));
      check("rnd_product", 32'(y), 32'(ref_mul(ra, rb)));
      start = 1'b0;
      tick();
    end

    // Held start: stays in DONE, y stable, new datain ignored.
    start_op(8'h5A, 8'h33);
    wait_done(n);
    check("held_product", 32'(y), 32'(ref_mul(8'h5A, 8'h33)));
    for (int k = 0; k < 4; k++) begin
      datain = W'($urandom);
      tick();
      check("held_done", 32'(done), 32'd1);
      check("held_y", 32'(y), 32'(ref_mul(8'h5A, 8'h33)));
    end
    start = 1'b0;
    tick();
    check("held_release", 32'(done), 32'd0);
    start_op(8'h0C, 8'h0D);
    wait_done(n);
    check("held_second_latency", 32'(n), 32'(W));
    check("held_second_product", 32'(y), 32'd156);
    start = 1'b0;
    tick();

    // Start drops so that it is sampled low at E0+4.
    start_op(8'hB7, 8'h9E);
    tick();
    tick();
    start = 1'b0;
    wait_done(n);
    check("drop_latency", 32'(n), 32'(W - 2));
    check("drop_product", 32'(y), 32'(ref_mul(8'hB7, 8'h9E)));
    tick();
    check("drop_done_one_cycle", 32'(done), 32'd0);
    tick();
    check("drop_stays_idle", 32'(done), 32'd0);

    // Reset sampled low at E0+5 discards the partial product.
    start_op(8'hA5, 8'h3C);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    check("midrst_idle", 32'(done), 32'd0);
    start_op(8'h07, 8'h06);
    wait_done(n);
    check("midrst_latency", 32'(n), 32'(W));
    check("midrst_product", 32'(y), 32'd42);
    start = 1'b0;
    tick();

    // Idle: no activity for 20 cycles.
    held = y;
    for (int k = 0; k < 20; k++) begin
      datain = W'($urandom);
      tick();
      check("idle_done", 32'(done), 32'd0);
      check("idle_y", 32'(y), 32'(held));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
